// File: rtl/sha3_theta_pipe_if.sv
// Handshake and state bundle for the Keccak theta pipeline.
// master drives states in; slave is the theta block.
interface sha3_theta_pipe_if #(
    parameter int LANE_W = 64
);
    logic [0:4][LANE_W-1:0] isa;
    logic [0:4][LANE_W-1:0] isb;
    logic [0:4][LANE_W-1:0] isc;
    logic [0:4][LANE_W-1:0] isd;
    logic [0:4][LANE_W-1:0] ise;
    logic                   sample;
    logic                   bypass;
    logic                   hold;
    logic                   ready;
    logic [0:4][LANE_W-1:0] osa;
    logic [0:4][LANE_W-1:0] osb;
    logic [0:4][LANE_W-1:0] osc;
    logic [0:4][LANE_W-1:0] osd;
    logic [0:4][LANE_W-1:0] ose;
    logic                   good;
    logic                   drop;

    modport master (
        output isa, isb, isc, isd, ise,
        output sample, bypass, hold,
        input  ready,
        input  osa, osb, osc, osd, ose,
        input  good, drop
    );

    modport slave (
        input  isa, isb, isc, isd, ise,
        input  sample, bypass, hold,
        output ready,
        output osa, osb, osc, osd, ose,
        output good, drop
    );
endinterface

// File: rtl/sha3_theta_pipe.sv
// Keccak-f theta step, 1 or 2 register stages, valid/ready with stall.
// Bypass flag travels with each state through the pipe.
module sha3_theta_pipe #(
    parameter int    LANE_W             = 64,
    parameter int    PIPE               = 1,
    parameter string BINARY_LOGIC_STYLE = "basic"
) (
    input  logic              clk,
    input  logic              rst,
    sha3_theta_pipe_if.slave  bus
);

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [0:4]       row_t;
    typedef row_t  [0:4]       st_t;

    typedef struct packed {
        st_t  a;
        row_t c;
        logic byp;
    } s1_t;

    if (!(LANE_W == 8 || LANE_W == 16 ||
          LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
        $error("LANE_W must be 8, 16, 32 or 64");
    end

    if (!(PIPE == 1 || PIPE == 2)) begin : g_bad_pipe
        $error("PIPE must be 1 or 2");
    end

    // Non-basic style builds XOR from AND/OR terms; same truth table.
    function automatic lane_t bx(lane_t a, lane_t b);
        if (BINARY_LOGIC_STYLE == "basic") begin
            return a ^ b;
        end
        return (a | b) & ~(a & b);
    endfunction

    function automatic lane_t rotl1(lane_t v);
        return {v[LANE_W-2:0], v[LANE_W-1]};
    endfunction

    function automatic row_t colpar(st_t a);
        row_t c;
        for (int x = 0; x < 5; x++) begin
            c[x] = a[0][x];
            for (int y = 1; y < 5; y++) begin
                c[x] = bx(c[x], a[y][x]);
            end
        end
        return c;
    endfunction

    function automatic row_t dcol(row_t c);
        row_t d;
        for (int x = 0; x < 5; x++) begin
            d[x] = bx(c[(x + 4) % 5], rotl1(c[(x + 1) % 5]));
        end
        return d;
    endfunction

    function automatic st_t apply(st_t a, row_t d, logic byp);
        st_t r;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                r[y][x] = byp ? a[y][x] : bx(a[y][x], d[x]);
            end
        end
        return r;
    endfunction

    st_t  in_st;
    st_t  l_st;
    logic l_v;
    logic l_load;
    logic ready;
    logic accept;
    logic drop_q;

    always_comb begin
        in_st    = '0;
        in_st[0] = bus.isa;
        in_st[1] = bus.isb;
        in_st[2] = bus.isc;
        in_st[3] = bus.isd;
        in_st[4] = bus.ise;
    end

    assign l_load = !l_v || !bus.hold;
    assign accept = bus.sample && ready;

    if (PIPE == 1) begin : g_p1
        assign ready = l_load;

        always_ff @(posedge clk) begin
            if (rst) begin
                l_v  <= 1'b0;
                l_st <= '0;
            end else if (l_load) begin
                l_v <= accept;
                if (accept) begin
                    l_st <= apply(in_st, dcol(colpar(in_st)),
                                  bus.bypass);
                end
            end
        end
    end else begin : g_p2
        s1_t  s1_q;
        logic s1_v;
        logic s1_adv;

        assign s1_adv = s1_v && l_load;
        assign ready  = !s1_v || s1_adv;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v <= 1'b0;
                s1_q <= '0;
            end else if (ready) begin
                s1_v <= accept;
                if (accept) begin
                    s1_q.a   <= in_st;
                    s1_q.c   <= colpar(in_st);
                    s1_q.byp <= bus.bypass;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                l_v  <= 1'b0;
                l_st <= '0;
            end else if (l_load) begin
                l_v <= s1_v;
                if (s1_v) begin
                    l_st <= apply(s1_q.a, dcol(s1_q.c), s1_q.byp);
                end
            end
        end
    end

    // Sticky: any sample offered while full is lost and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (bus.sample && !ready) begin
            drop_q <= 1'b1;
        end
    end

    assign bus.ready = ready;
    assign bus.good  = l_v;
    assign bus.drop  = drop_q;
    assign bus.osa   = l_st[0];
    assign bus.osb   = l_st[1];
    assign bus.osc   = l_st[2];
    assign bus.osd   = l_st[3];
    assign bus.ose   = l_st[4];

endmodule
